// File: rtl/exp_scale_pkg.sv
// Shared widths, payload types and the shift/saturate helper for the exponent-scale lookup.
package exp_scale_pkg;

    localparam int unsigned DEF_IDX_W  = 4;
    localparam int unsigned DEF_OUT_W  = 12;
    localparam int unsigned DEF_FRAC_W = 8;
    localparam int unsigned DEF_SH_W   = 2;
    // Wide enough to hold the largest entry shifted by the largest shift amount.
    localparam int unsigned WIDE_W     = DEF_OUT_W + (2 ** DEF_SH_W) - 1;

    typedef logic [DEF_OUT_W-1:0] scale_t;
    typedef logic [DEF_SH_W-1:0]  shift_t;

    // S1 payload: looked-up entry plus the shift still to be applied.
    typedef struct packed {
        logic   valid;
        scale_t value;
        shift_t shift;
    } stage_t;

    // Shift/saturate result.
    typedef struct packed {
        logic   sat;
        scale_t value;
    } sat_res_t;

    // S2 payload: final scale word as presented downstream.
    typedef struct packed {
        logic   valid;
        logic   sat;
        scale_t value;
    } result_t;

    // Fixed-point 1.0 for a given number of fractional bits.
    function automatic scale_t unity(input int unsigned frac_w);
        return scale_t'(1) << frac_w;
    endfunction

    // Left shift with clamp to all ones when any bit escapes the scale word.
    function automatic sat_res_t sat_shl(input scale_t entry, input shift_t sh);
        logic [WIDE_W-1:0] wide;
        sat_res_t          res;
        wide      = WIDE_W'(entry) << sh;
        res.sat   = |wide[WIDE_W-1:DEF_OUT_W];
        res.value = res.sat ? {DEF_OUT_W{1'b1}} : wide[DEF_OUT_W-1:0];
        return res;
    endfunction

endpackage

// File: rtl/exp_scale_lut_pipe_table.sv
// Programmable scale table: one write port, one combinational read port, resets to UNITY.
module exp_scale_table #(
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned OUT_W  = 12,
    parameter int unsigned FRAC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [IDX_W-1:0] wr_addr_i,
    input  logic [OUT_W-1:0] wr_data_i,
    input  logic [IDX_W-1:0] rd_addr_i,
    output logic [OUT_W-1:0] rd_data_o
);

    localparam int unsigned     DEPTH = 2 ** IDX_W;
    localparam logic [OUT_W-1:0] UNITY = OUT_W'(1) << FRAC_W;

    logic [OUT_W-1:0] mem_q [DEPTH];

    // Entry storage; a read in the write cycle still sees the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i[IDX_W-1:0]] <= UNITY;
            end
        end else if (we_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/exp_scale_lut_pipe.sv
// Exponent-index to scale-factor lookup with post-lookup saturating shift,
// behind a two-stage stallable valid/ready pipeline. Widths follow the
// package defaults, which also size the internal stage payloads.
module exp_scale_lut_pipe
    import exp_scale_pkg::*;
#(
    parameter int unsigned IDX_W  = DEF_IDX_W,
    parameter int unsigned OUT_W  = DEF_OUT_W,
    parameter int unsigned FRAC_W = DEF_FRAC_W,
    parameter int unsigned SH_W   = DEF_SH_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [OUT_W-1:0] cfg_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_idx,
    input  logic [SH_W-1:0]  in_shift,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_scale,
    output logic             out_sat
);

    stage_t           s1_q, s1_d;
    result_t          s2_q, s2_d;
    sat_res_t         shl_c;
    logic             s1_en_c, s2_en_c;
    logic [OUT_W-1:0] rd_data;

    exp_scale_table #(
        .IDX_W (IDX_W),
        .OUT_W (OUT_W),
        .FRAC_W(FRAC_W)
    ) u_table (
        .clk      (clk),
        .rst      (rst),
        .we_i     (cfg_we),
        .wr_addr_i(cfg_addr),
        .wr_data_i(cfg_data),
        .rd_addr_i(in_idx),
        .rd_data_o(rd_data)
    );

    // Per-stage load enables: a stage advances when empty or when its consumer advances.
    always_comb begin
        s2_en_c = ~s2_q.valid | out_ready;
        s1_en_c = ~s1_q.valid | s2_en_c;
    end

    assign in_ready = s1_en_c;

    // Next-state for both stages; stalled stages hold their contents.
    always_comb begin
        s1_d  = s1_q;
        s2_d  = s2_q;
        shl_c = sat_shl(s1_q.value, s1_q.shift);
        if (s1_en_c) begin
            s1_d.valid = in_valid;
            s1_d.value = rd_data;
            s1_d.shift = in_shift;
        end
        if (s2_en_c) begin
            s2_d.valid = s1_q.valid;
            s2_d.sat   = shl_c.sat;
            s2_d.value = shl_c.value;
        end
    end

    // Pipeline registers; reset discards anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign out_valid = s2_q.valid;
    assign out_scale = s2_q.value;
    assign out_sat   = s2_q.sat;

endmodule

// File: tb/tb_exp_scale_lut_pipe.sv
// Self-checking bench for exp_scale_lut_pipe: constant vectors, directed corner
// sequences and randomized streams against an arithmetic reference model.
module tb_exp_scale_lut_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [11:0] cfg_data;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_idx;
    logic [1:0]  in_shift;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_scale;
    logic        out_sat;

    exp_scale_lut_pipe dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_idx   (in_idx),
        .in_shift (in_shift),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_scale(out_scale),
        .out_sat  (out_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  idx;
        logic [1:0]  sh;
        logic [11:0] scale;
        logic        sat;
    } vec_t;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc    = 0;

    // Reference model: table contents plus ordered queue of {sat, scale} still owed.
    int unsigned tbl [16];
    logic [12:0] mq [$];
    logic [12:0] obs [$];
    int unsigned out_cyc [$];
    logic        acc_in;
    logic        acc_out;

    task automatic chk(input bit ok, input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scale = entry * 2^sh, clamped to 12 bits; shift 0 can never exceed.
    function automatic logic [12:0] ref_shl(input int unsigned e, input int unsigned sh);
        int unsigned v;
        v = e * (32'd1 << sh);
        if (v > 32'd4095) return {1'b1, 12'hFFF};
        return {1'b0, v[11:0]};
    endfunction

    // One clock: called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cycle();
        logic [12:0] e;
        logic [12:0] got;
        logic        pre_stall;
        logic [11:0] ps;
        logic        pt;
        bit          exp_rdy;
        e = '0;
        #1;
        acc_in  = in_valid && in_ready;
        acc_out = out_valid && out_ready;
        exp_rdy = !(mq.size() == 2 && !out_ready);
        chk(in_ready === exp_rdy, "in_ready", 32'(in_ready), 32'(exp_rdy));
        if (mq.size() == 0) chk(out_valid === 1'b0, "out_valid_empty", 32'(out_valid), 0);
        if (acc_out) begin
            got = {out_sat, out_scale};
            obs.push_back(got);
            out_cyc.push_back(cyc);
            if (mq.size() == 0) begin
                chk(1'b0, "unexpected_output", 32'(got), 0);
            end else begin
                chk(got === mq[0], "scoreboard", 32'(got), 32'(mq[0]));
                void'(mq.pop_front());
            end
        end
        if (acc_in) e = ref_shl(tbl[in_idx], 32'(in_shift));
        pre_stall = out_valid && !out_ready;
        ps = out_scale;
        pt = out_sat;
        @(posedge clk);
        if (acc_in) mq.push_back(e);
        if (cfg_we) tbl[cfg_addr] = 32'(cfg_data);
        cyc++;
        @(negedge clk);
        if (pre_stall) begin
            chk(out_valid === 1'b1, "stall_valid", 32'(out_valid), 1);
            chk({out_sat, out_scale} === {pt, ps}, "stall_hold", 32'({out_sat, out_scale}), 32'({pt, ps}));
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [11:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        cycle();
        cfg_we = 1'b0;
    endtask

    task automatic send(input logic [3:0] idx, input logic [1:0] sh);
        bit done = 0;
        in_valid = 1'b1; in_idx = idx; in_shift = sh;
        for (int i = 0; i < 50 && !done; i++) begin
            cycle();
            done = acc_in;
        end
        in_valid = 1'b0;
        if (!done) chk(1'b0, "send_timeout", 0, 1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 20 && mq.size() != 0; i++) cycle();
        chk(mq.size() == 0, "drain_timeout", 32'(mq.size()), 0);
    endtask

    task automatic reset_model();
        mq.delete();
        for (int i = 0; i < 16; i++) tbl[i] = 32'h100;
    endtask

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{4'd3,  2'd0, 12'h100, 1'b0};
        vecs[1]  = '{4'd3,  2'd3, 12'h800, 1'b0};
        vecs[2]  = '{4'd1,  2'd0, 12'h2B8, 1'b0};
        vecs[3]  = '{4'd1,  2'd2, 12'hAE0, 1'b0};
        vecs[4]  = '{4'd1,  2'd3, 12'hFFF, 1'b1};
        vecs[5]  = '{4'd2,  2'd0, 12'hFFF, 1'b0};
        vecs[6]  = '{4'd2,  2'd1, 12'hFFF, 1'b1};
        vecs[7]  = '{4'd4,  2'd3, 12'h008, 1'b0};
        vecs[8]  = '{4'd6,  2'd1, 12'hFFF, 1'b1};
        vecs[9]  = '{4'd6,  2'd0, 12'h800, 1'b0};
        vecs[10] = '{4'd0,  2'd3, 12'h800, 1'b0};
        vecs[11] = '{4'd15, 2'd2, 12'h400, 1'b0};

        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        in_valid = 1'b0; in_idx = '0; in_shift = '0; out_ready = 1'b1;
        acc_in = 1'b0; acc_out = 1'b0;
        reset_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk(out_valid === 1'b0, "rst_out_valid", 32'(out_valid), 0);
        chk(out_scale === 12'h000, "rst_out_scale", 32'(out_scale), 0);
        chk(out_sat === 1'b0, "rst_out_sat", 32'(out_sat), 0);
        chk(in_ready === 1'b1, "rst_in_ready", 32'(in_ready), 1);
        rst = 1'b0;

        // Latency: result appears after the second edge counting the accept edge.
        in_valid = 1'b1; in_idx = 4'd3; in_shift = 2'd0;
        cycle();
        chk(acc_in === 1'b1, "lat_accept", 32'(acc_in), 1);
        chk(out_valid === 1'b0, "lat_s1_only", 32'(out_valid), 0);
        in_valid = 1'b0;
        cycle();
        chk(out_valid === 1'b1, "lat_valid", 32'(out_valid), 1);
        chk(out_scale === 12'h100, "lat_scale", 32'(out_scale), 32'h100);
        chk(out_sat === 1'b0, "lat_sat", 32'(out_sat), 0);
        drain();

        // Constant vector table.
        wr(4'd1, 12'h2B8);
        wr(4'd2, 12'hFFF);
        wr(4'd4, 12'h001);
        wr(4'd6, 12'h800);
        foreach (vecs[k]) begin
            obs.delete();
            send(vecs[k].idx, vecs[k].sh);
            drain();
            chk(obs.size() == 1, "vec_count", 32'(obs.size()), 1);
            if (obs.size() == 1)
                chk(obs[0] === {vecs[k].sat, vecs[k].scale}, $sformatf("vec%0d", k),
                    32'(obs[0]), 32'({vecs[k].sat, vecs[k].scale}));
        end

        // Same-cycle write and lookup returns the old entry; the next lookup the new one.
        obs.delete();
        cfg_we = 1'b1; cfg_addr = 4'd5; cfg_data = 12'h0CB;
        in_valid = 1'b1; in_idx = 4'd5; in_shift = 2'd0;
        cycle();
        cfg_we = 1'b0;
        cycle();
        in_valid = 1'b0;
        drain();
        chk(obs.size() == 2, "coll_count", 32'(obs.size()), 2);
        if (obs.size() == 2) begin
            chk(obs[0] === 13'h0100, "coll_old", 32'(obs[0]), 32'h100);
            chk(obs[1] === 13'h00CB, "coll_new", 32'(obs[1]), 32'h0CB);
        end

        // In-flight result unaffected by a later write to its entry.
        obs.delete();
        out_ready = 1'b0;
        send(4'd5, 2'd1);
        wr(4'd5, 12'h7FF);
        drain();
        chk(obs.size() == 1 && obs[0] === 13'h0196, "inflight_hold", 32'(obs.size() == 1 ? obs[0] : 13'h0), 32'h196);

        // Backpressure stream of idx 0..7 with random stalls.
        for (int i = 0; i < 8; i++) wr(4'(i), 12'($urandom_range(0, 4095)));
        obs.delete();
        begin
            int unsigned sent = 0;
            for (int i = 0; i < 300 && (sent < 8 || mq.size() != 0); i++) begin
                out_ready = 1'($urandom_range(0, 1));
                in_valid  = (sent < 8);
                in_idx    = 4'(sent);
                in_shift  = 2'($urandom_range(0, 3));
                cycle();
                if (acc_in) sent++;
            end
            in_valid = 1'b0;
            chk(sent == 8, "bp_sent", sent, 8);
        end
        drain();
        chk(obs.size() == 8, "bp_count", 32'(obs.size()), 8);

        // Reset with two transactions in flight and a cfg write pending.
        out_ready = 1'b0;
        in_valid = 1'b1; in_idx = 4'd1; in_shift = 2'd0;
        cycle();
        in_idx = 4'd2;
        cycle();
        in_valid = 1'b0;
        chk(mq.size() == 2, "rst_inflight", 32'(mq.size()), 2);
        #2 rst = 1'b1;
        #1;
        chk(out_valid === 1'b0, "async_rst_valid", 32'(out_valid), 0);
        chk(out_scale === 12'h000, "async_rst_scale", 32'(out_scale), 0);
        chk(in_ready === 1'b1, "async_rst_ready", 32'(in_ready), 1);
        cfg_we = 1'b1; cfg_addr = 4'd3; cfg_data = 12'h777;
        @(posedge clk);
        @(negedge clk);
        cfg_we = 1'b0;
        rst = 1'b0;
        reset_model();
        out_ready = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            obs.delete();
            send(4'(i), 2'd0);
            drain();
            chk(obs.size() == 1 && obs[0] === 13'h0100, $sformatf("rst_tbl%0d", i),
                32'(obs.size() == 1 ? obs[0] : 13'h0), 32'h100);
        end

        // Full-rate random stream with concurrent random table writes.
        obs.delete();
        out_cyc.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_idx   = 4'($urandom_range(0, 15));
            in_shift = 2'($urandom_range(0, 3));
            cfg_we   = 1'($urandom_range(0, 1));
            cfg_addr = 4'($urandom_range(0, 15));
            cfg_data = 12'($urandom_range(0, 4095));
            cycle();
        end
        in_valid = 1'b0;
        cfg_we = 1'b0;
        drain();
        chk(obs.size() == 16, "fr_count", 32'(obs.size()), 16);
        if (out_cyc.size() == 16)
            chk(out_cyc[15] - out_cyc[0] == 15, "fr_consecutive", out_cyc[15] - out_cyc[0], 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1);
    end

endmodule
